// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access sizes, arbiter states,
// the request bundle and the default lock bound.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HWORD = 2'd1,
        MEM_WORD  = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_M1_LOCK = 2'd1,
        ARB_FORCE0  = 2'd2
    } arb_state_t;

    localparam int MEM_ADDR_W       = 32;
    localparam int MEM_DATA_W       = 32;
    localparam int MAX_LOCK_DEFAULT = 8;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        mem_size_t             size;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the shared memory port around the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import dmem_arbiter_pkg::*;

    logic              i_m0_req;
    logic              i_m0_we;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DATA_W-1:0] i_m0_wdata;
    mem_size_t         i_m0_size;
    logic              o_m0_gnt;
    logic              o_m0_rvalid;
    logic [DATA_W-1:0] o_m0_rdata;
    logic              o_m0_stall;

    logic              i_m1_req;
    logic              i_m1_we;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DATA_W-1:0] i_m1_wdata;
    mem_size_t         i_m1_size;
    logic              i_m1_lock;
    logic              o_m1_gnt;
    logic              o_m1_rvalid;
    logic [DATA_W-1:0] o_m1_rdata;

    logic              o_mem_re;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    mem_size_t         o_mem_size;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_size,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata, o_m0_stall,
        input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_size, i_m1_lock,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        output o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size,
        input  i_mem_rdata
    );

    modport master (
        output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_size,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata, o_m0_stall,
        output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_size, i_m1_lock,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        input  o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size,
        output i_mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// rr_ptr favours (0 = m0, 1 = m1). Grant is one-hot or zero.
module dmem_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the memory stage (m0) and a secondary
// master (m1) with round-robin arbitration, bounded m1 locking and 1-cycle read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = MAX_LOCK_DEFAULT,
    parameter int RD_LAT   = 1
) (
    input logic          i_clk,
    input logic          i_rst,
    dmem_arbiter_if.slave bus
);

    generate
        if (RD_LAT != 1) begin : g_bad_rd_lat
            $error("dmem_arbiter: only RD_LAT=1 is supported");
        end
        if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
            $error("dmem_arbiter: MAX_LOCK must be within 1..255");
        end
        if (ADDR_W > MEM_ADDR_W || DATA_W > MEM_DATA_W) begin : g_bad_width
            $error("dmem_arbiter: ADDR_W/DATA_W exceed the mem_req_t field widths");
        end
    endgenerate

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    arb_state_t state, state_next;
    logic       rr_ptr, rr_ptr_next;
    logic [7:0] lock_cnt, lock_cnt_next;
    logic       pend0, pend1;
    logic       gnt0, gnt1;
    logic [1:0] rr_gnt;
    mem_req_t   m0_cmd, m1_cmd, mem_cmd;

    dmem_arbiter_rr_arb2 u_rr_arb2 (
        .req    ({bus.i_m1_req, bus.i_m0_req}),
        .rr_ptr (rr_ptr),
        .gnt    (rr_gnt)
    );

    // Registered arbiter state plus the one-deep read-return pending flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= 1'b0;
            lock_cnt <= 8'd0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            lock_cnt <= lock_cnt_next;
            pend0    <= gnt0 & ~bus.i_m0_we;
            pend1    <= gnt1 & ~bus.i_m1_we;
        end
    end

    // The lock counter measures how long m0 has been kept waiting, not how busy m1 is.
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        lock_cnt_next = lock_cnt;
        if (gnt0) rr_ptr_next = 1'b1;
        if (gnt1) rr_ptr_next = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (gnt1 && bus.i_m1_lock) state_next = ARB_M1_LOCK;
            end
            ARB_M1_LOCK: begin
                if (bus.i_m0_req) lock_cnt_next = lock_cnt + 8'd1;
                if (gnt1 && !bus.i_m1_lock) begin
                    state_next    = ARB_IDLE;
                    rr_ptr_next   = 1'b0;
                    lock_cnt_next = 8'd0;
                end else if (bus.i_m0_req && lock_cnt_next >= LOCK_LIMIT) begin
                    state_next = ARB_FORCE0;
                end
            end
            ARB_FORCE0: begin
                lock_cnt_next = 8'd0;
                state_next    = bus.i_m1_lock ? ARB_M1_LOCK : ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_rst) begin
            case (state)
                ARB_IDLE: begin
                    gnt0 = rr_gnt[0];
                    gnt1 = rr_gnt[1];
                end
                ARB_M1_LOCK: gnt1 = bus.i_m1_req;
                ARB_FORCE0:  gnt0 = bus.i_m0_req;
                default: ;
            endcase
        end
    end

    assign m0_cmd = '{we: bus.i_m0_we, addr: MEM_ADDR_W'(bus.i_m0_addr),
                      wdata: MEM_DATA_W'(bus.i_m0_wdata), size: bus.i_m0_size};
    assign m1_cmd = '{we: bus.i_m1_we, addr: MEM_ADDR_W'(bus.i_m1_addr),
                      wdata: MEM_DATA_W'(bus.i_m1_wdata), size: bus.i_m1_size};

    // An idle port drives an all-zero command so downstream decode sees no stale address.
    always_comb begin
        mem_cmd = '0;
        if (gnt0) begin
            mem_cmd = m0_cmd;
        end else if (gnt1) begin
            mem_cmd = m1_cmd;
        end
    end

    assign bus.o_mem_re    = (gnt0 | gnt1) & ~mem_cmd.we;
    assign bus.o_mem_we    = (gnt0 | gnt1) & mem_cmd.we;
    assign bus.o_mem_addr  = ADDR_W'(mem_cmd.addr);
    assign bus.o_mem_wdata = DATA_W'(mem_cmd.wdata);
    assign bus.o_mem_size  = mem_cmd.size;

    assign bus.o_m0_gnt    = gnt0;
    assign bus.o_m1_gnt    = gnt1;
    assign bus.o_m0_stall  = bus.i_m0_req & ~gnt0 & ~i_rst;
    assign bus.o_m0_rvalid = pend0 & ~i_rst;
    assign bus.o_m1_rvalid = pend1 & ~i_rst;
    assign bus.o_m0_rdata  = bus.o_m0_rvalid ? bus.i_mem_rdata : '0;
    assign bus.o_m1_rdata  = bus.o_m1_rvalid ? bus.i_mem_rdata : '0;

    assert property (@(posedge i_clk) !(gnt0 && gnt1));

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (data_mem plus the MMIO decode behind it) between two requesters.
  - m0: the pipeline's memory stage (load/store).
  - m1: a secondary master, i.e. the UART boot loader or debug writer.
- Arbitration is round-robin. m1 may lock the port for bursts, with a bounded lock length so the CPU never starves.
- Generates the memory-stage stall and returns read data with fixed latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_LOCK, 8, max consecutive m1 locked beats while m0 is waiting (range 1..255).
- RD_LAT, 1, memory read latency in cycles. Only 1 is supported; any other value is an elaboration error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_m0_req  in  1  CPU access request
- i_m0_we  in  1  1=store, 0=load
- i_m0_addr  in  ADDR_W  byte address
- i_m0_wdata  in  DATA_W  store data
- i_m0_size  in  2  mem_size_t (BYTE/HWORD/WORD)
- o_m0_gnt  out  1  access accepted this cycle
- o_m0_rvalid  out  1  load data valid
- o_m0_rdata  out  DATA_W  load data
- o_m0_stall  out  1  =i_m0_req & ~o_m0_gnt, freezes the pipeline
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_size: as for m0
- i_m1_lock  in  1  keep ownership after this beat
- o_m1_gnt, o_m1_rvalid, o_m1_rdata: as for m0
- o_mem_re  out  1  memory read strobe
- o_mem_we  out  1  memory write strobe
- o_mem_addr  out  ADDR_W
- o_mem_wdata  out  DATA_W
- o_mem_size  out  2
- i_mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after o_mem_re

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high on i_rst.
- Reset state:
  - state=ARB_IDLE, rr_ptr=0 (m0 favoured), lock_cnt=0.
  - rvalid pending flags cleared.
  - All outputs 0 during and after the reset cycle.
- Grant is combinational from current requests plus registered state. The memory command is driven in the same cycle as the grant, and at most one grant is issued per cycle.
- Mux: o_mem_* carries the granted master's fields. With no grant, o_mem_re=o_mem_we=0 and addr/wdata/size=0.
- States:
  - ARB_IDLE: only one requester → grant it. Both requesting → grant the master selected by rr_ptr. After any grant, rr_ptr points to the other master. If m1 is granted with i_m1_lock=1 → ARB_M1_LOCK.
  - ARB_M1_LOCK:
    - m1 has exclusive grant; m0 is denied.
    - lock_cnt increments on each m1 grant while i_m0_req=1; it holds while m0 is idle.
    - i_m1_lock=0 on a granted beat → that beat completes, then ARB_IDLE with rr_ptr=0.
    - lock_cnt reaching MAX_LOCK with m0 requesting → ARB_FORCE0.
    - m1 dropping i_m1_req while locked → port is held idle, m0 still denied, lock_cnt still advances while m0 waits.
  - ARB_FORCE0: m0 is granted exactly one beat if requesting; if not, the state exits immediately. lock_cnt clears and the state returns to ARB_M1_LOCK if i_m1_lock=1, else ARB_IDLE.
- Read return:
  - Granted load → rvalid pending for that master, registered.
  - The next cycle: o_mX_rvalid=1 for one cycle, o_mX_rdata=i_mem_rdata. rdata is 0 when rvalid=0.
  - Back-to-back loads from alternating masters return in grant order, one per cycle.
- Stores produce no rvalid.
- Stall: o_m0_stall is combinational and must not depend on o_m0_rvalid. The pipeline holds the request stable while stalled, and requesters must keep req and fields stable until granted.
- Reset mid-operation: pending rvalids are discarded (no rvalid the cycle after reset), lock is released, and no memory strobe is driven during the reset cycle.
- Simultaneous grant to m0 and m1 is illegal; an assertion checks `!(o_m0_gnt && o_m1_gnt)`.

Decomposition:
- rv_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_M1_LOCK, ARB_FORCE0}
  - mem_req_t struct {we, addr, wdata, size}
  - MAX_LOCK default constant
- Reuse mem_size_t.
- One sub-module, rr_arb2: a 2-way round-robin pick from req[1:0] and rr_ptr, returning a one-hot grant. Lock/force logic, the mux and read return stay in dmem_arbiter.
- Top-level integration places dmem_arbiter between mem_stage's address/data path and data_mem/MMIO decode.

Test Plan:
- Reset: assert i_rst for 2 cycles with both reqs high → all outputs 0. The first cycle after reset grants m0 (rr_ptr=0).
- Solo load: m0 load addr 0x40, data_mem[0x40]=0xDEADBEEF → o_m0_gnt=1 and o_mem_re=1 in cycle N; o_m0_rvalid=1 with rdata 0xDEADBEEF in N+1; stall=0.
- Contention round-robin: both request continuously without lock → grants alternate m0,m1,m0,m1. o_m0_stall=1 exactly on m1 cycles.
- Lock starvation bound: m1 locked writes with MAX_LOCK=4, then m0 load arrives → 4 m1 beats, 1 m0 beat (FORCE0), then m1 resumes. Verify ≤4 cycles of m0 stall.
- Lock release: m1 writes 3 beats with lock=1,1,0 while m0 waits → m0 is granted the cycle after the third beat. Memory holds the 3 written values.
- Reset mid-read: m1 load granted in cycle N, i_rst=1 in N+1 → no o_m1_rvalid at any point, state returns to ARB_IDLE, and m0 is granted first afterwards.
